// File: rtl/alu_cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cdb_arbiter_if
//  Purpose  : Bundles the request side (reservation-station entries) and the
//             common-data-bus side of the ALU CDB arbiter into one interface.
//  Ports    : req/data_req/tag_req  - per-entry completion, result, ROB tag
//             flush, cdb_ready      - pipeline flush and CDB consumer ready
//             grant                 - combinational one-hot grant to entries
//             cdb_valid/data/tag/src- registered CDB word
//             stall_cnt             - saturating backpressure counter
//  Modports : master - environment (station + CDB consumer)
//             slave  - the arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface alu_cdb_arbiter_if #(
    parameter int NUM_REQ        = 8,
    parameter int REQ_INDEX_BITS = 3,
    parameter int ROB_INDEX_BITS = 4
);
    logic [NUM_REQ-1:0]                     req;
    logic [NUM_REQ-1:0][31:0]               data_req;
    logic [NUM_REQ-1:0][ROB_INDEX_BITS-1:0] tag_req;
    logic                                   flush;
    logic                                   cdb_ready;
    logic [NUM_REQ-1:0]                     grant;
    logic                                   cdb_valid;
    logic [31:0]                            cdb_data;
    logic [ROB_INDEX_BITS-1:0]              cdb_tag;
    logic [REQ_INDEX_BITS-1:0]              cdb_src;
    logic [15:0]                            stall_cnt;

    modport master (
        output req, data_req, tag_req, flush, cdb_ready,
        input  grant, cdb_valid, cdb_data, cdb_tag, cdb_src, stall_cnt
    );

    modport slave (
        input  req, data_req, tag_req, flush, cdb_ready,
        output grant, cdb_valid, cdb_data, cdb_tag, cdb_src, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cdb_arbiter
//  Purpose  : Round-robin scheduler sharing the single CDB among the ALU
//             reservation-station entries. Picks at most one completed entry
//             per cycle, grants it, and captures its result/tag into a
//             registered CDB word that holds under consumer backpressure.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - alu_cdb_arbiter_if.slave (requests, grant, CDB word)
//  Revision : 1.0  initial release
// ============================================================================
module alu_cdb_arbiter #(
    parameter int NUM_REQ        = 8,
    parameter int REQ_INDEX_BITS = 3,
    parameter int ROB_INDEX_BITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_cdb_arbiter_if.slave   bus
);

    // FSM state is exactly the CDB valid bit
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    localparam logic [REQ_INDEX_BITS-1:0] c_last_idx = REQ_INDEX_BITS'(NUM_REQ - 1);
    localparam logic [15:0]               c_stall_max = 16'hFFFF;

    logic [0:0]                state_q,     state_d;
    logic [REQ_INDEX_BITS-1:0] rr_ptr_q,    rr_ptr_d;
    logic [NUM_REQ-1:0]        mask_q,      mask_d;
    logic [31:0]               cdb_data_q,  cdb_data_d;
    logic [ROB_INDEX_BITS-1:0] cdb_tag_q,   cdb_tag_d;
    logic [REQ_INDEX_BITS-1:0] cdb_src_q,   cdb_src_d;
    logic [15:0]               stall_cnt_q, stall_cnt_d;

    logic                      can_load;
    logic [NUM_REQ-1:0]        eligible;
    logic                      sel_found;
    logic [REQ_INDEX_BITS-1:0] sel_idx;
    logic [REQ_INDEX_BITS-1:0] probe_idx;
    logic                      do_grant;
    logic [NUM_REQ-1:0]        grant_w;

    // ------------------------------------------------------------------
    // Selection: rotating-priority scan starting at rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        // The output register may be reloaded when empty, or when the word
        // currently on the bus is being taken this very cycle.
        can_load  = !bus.flush && ((state_q == c_st_empty) || bus.cdb_ready);
        // The entry granted last cycle still shows req=1 for one more cycle
        // because the station clears its done bit a cycle late.
        eligible  = bus.req & ~mask_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        probe_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            probe_idx = REQ_INDEX_BITS'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!sel_found && eligible[probe_idx]) begin
                sel_found = 1'b1;
                sel_idx   = probe_idx;
            end
        end
        do_grant = can_load && sel_found;
    end

    // Grant is suppressed while reset is held so requesters never consume
    // an entry that the arbiter cannot capture.
    always_comb begin
        grant_w = '0;
        if (rst && do_grant) begin
            grant_w[sel_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_st_empty;
            rr_ptr_q    <= '0;
            mask_q      <= '0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            mask_q      <= mask_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = c_st_empty;
        end else begin
            case (state_q)
                c_st_empty: state_d = do_grant ? c_st_full : c_st_empty;
                c_st_full: begin
                    if (do_grant) begin
                        state_d = c_st_full;     // drain plus refill
                    end else if (bus.cdb_ready) begin
                        state_d = c_st_empty;    // drained, nothing to load
                    end else begin
                        state_d = c_st_full;     // hold under backpressure
                    end
                end
                default: state_d = c_st_empty;
            endcase
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mask_d      = '0;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        stall_cnt_d = stall_cnt_q;

        if (do_grant) begin
            cdb_data_d      = bus.data_req[sel_idx];
            cdb_tag_d       = bus.tag_req[sel_idx];
            cdb_src_d       = sel_idx;
            mask_d[sel_idx] = 1'b1;
            rr_ptr_d        = (sel_idx == c_last_idx) ? '0
                                                      : sel_idx + REQ_INDEX_BITS'(1);
        end

        if ((state_q == c_st_full) && !bus.cdb_ready && !bus.flush &&
            (stall_cnt_q != c_stall_max)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.grant     = grant_w;
        bus.cdb_valid = (state_q == c_st_full);
        bus.cdb_data  = cdb_data_q;
        bus.cdb_tag   = cdb_tag_q;
        bus.cdb_src   = cdb_src_q;
        bus.stall_cnt = stall_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cdb_arbiter
//  Purpose  : Self-checking bench for alu_cdb_arbiter. A behavioural model
//             (last-granted index, integer pointer, CDB word) predicts grant
//             and the registered CDB outputs every cycle; directed scenarios
//             add fixed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cdb_arbiter;

    localparam int NUM_REQ        = 8;
    localparam int REQ_INDEX_BITS = 3;
    localparam int ROB_INDEX_BITS = 4;

    logic clk;
    logic rst;

    alu_cdb_arbiter_if #(
        .NUM_REQ        (NUM_REQ),
        .REQ_INDEX_BITS (REQ_INDEX_BITS),
        .ROB_INDEX_BITS (ROB_INDEX_BITS)
    ) bus ();

    alu_cdb_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .REQ_INDEX_BITS (REQ_INDEX_BITS),
        .ROB_INDEX_BITS (ROB_INDEX_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          m_valid;
    logic [31:0] m_data;
    int          m_tag;
    int          m_src;
    int          m_ptr;
    int          m_last;   // index granted in the previous cycle, -1 if none
    int          m_stall;

    logic [NUM_REQ-1:0] g_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_tag = 0; m_src = 0;
        m_ptr = 0; m_last = -1; m_stall = 0;
    endtask

    // index the bus would go to this cycle, or -1
    function automatic int model_pick(input logic [NUM_REQ-1:0] r, input logic f, input logic rdy);
        if (f) return -1;
        if (m_valid != 0 && !rdy) return -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (m_ptr + i) % NUM_REQ;
            if (r[k] && k != m_last) return k;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string pfx);
        chk({pfx, "_valid"}, 32'(bus.cdb_valid), 32'(m_valid));
        chk({pfx, "_data"},  bus.cdb_data,       m_data);
        chk({pfx, "_tag"},   32'(bus.cdb_tag),   32'(m_tag));
        chk({pfx, "_src"},   32'(bus.cdb_src),   32'(m_src));
        chk({pfx, "_stall"}, 32'(bus.stall_cnt), 32'(m_stall));
    endtask

    // One clock cycle: drive inputs, check grant, clock, check CDB word.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic f, input logic rdy);
        int k;
        logic [NUM_REQ-1:0] exp_g;
        @(negedge clk);
        bus.req       = r;
        bus.flush     = f;
        bus.cdb_ready = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.data_req[i] = $urandom();
            bus.tag_req[i]  = ROB_INDEX_BITS'($urandom());
        end
        #1;
        k = model_pick(r, f, rdy);
        exp_g = '0;
        if (k >= 0) exp_g = NUM_REQ'(1) << k;
        g_obs = bus.grant;
        chk("grant", 32'(g_obs), 32'(exp_g));
        @(posedge clk);
        if (m_valid != 0 && !rdy && !f && m_stall < 65535) m_stall++;
        if (k >= 0) begin
            m_valid = 1;
            m_data  = bus.data_req[k];
            m_tag   = int'(bus.tag_req[k]);
            m_src   = k;
            m_ptr   = (k + 1) % NUM_REQ;
            m_last  = k;
        end else begin
            m_last = -1;
            if (f || rdy) m_valid = 0;
        end
        #1;
        check_outputs("cdb");
    endtask

    initial begin
        logic [NUM_REQ-1:0] r;
        model_reset();
        rst = 1'b0;
        bus.req = '1; bus.flush = 1'b0; bus.cdb_ready = 1'b1;
        bus.data_req = '0; bus.tag_req = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset_grant", 32'(bus.grant), 32'h0);
        @(negedge clk);
        bus.req = '0;
        rst = 1'b1;

        // single request from entry 5
        step(8'h20, 1'b0, 1'b1);
        chk("t1_grant", 32'(g_obs), 32'h20);
        chk("t1_valid", 32'(bus.cdb_valid), 32'h1);
        chk("t1_src",   32'(bus.cdb_src), 32'd5);
        step(8'h00, 1'b0, 1'b1);
        chk("t1_drain", 32'(bus.cdb_valid), 32'h0);

        // move pointer to 0, then full request vector for 9 cycles
        step(8'h80, 1'b0, 1'b1);
        chk("ptr_wrap_grant", 32'(g_obs), 32'h80);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            chk("rr_seq", 32'(g_obs), 32'(1) << (i % 8));
            chk("no_bubble", 32'(bus.cdb_valid), 32'h1);
        end

        // wrap-around: pointer 6 after granting 5, then 0 and 1
        step(8'h20, 1'b0, 1'b1);
        chk("wrap_g5", 32'(g_obs), 32'h20);
        step(8'h03, 1'b0, 1'b1);
        chk("wrap_g0", 32'(g_obs), 32'h01);
        step(8'h03, 1'b0, 1'b1);
        chk("wrap_g1", 32'(g_obs), 32'h02);

        // backpressure
        step(8'h04, 1'b0, 1'b1);
        chk("bp_g2", 32'(g_obs), 32'h04);
        for (int i = 0; i < 3; i++) begin
            step(8'h10, 1'b0, 1'b0);
            chk("bp_nogrant", 32'(g_obs), 32'h0);
            chk("bp_hold_src", 32'(bus.cdb_src), 32'd2);
        end
        chk("bp_stall", 32'(bus.stall_cnt), 32'd3);
        step(8'h10, 1'b0, 1'b1);
        chk("bp_release", 32'(g_obs), 32'h10);
        chk("bp_src4", 32'(bus.cdb_src), 32'd4);

        // flush while full with backpressure
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        chk("flush_grant", 32'(g_obs), 32'h0);
        chk("flush_valid", 32'(bus.cdb_valid), 32'h0);
        chk("flush_stall", 32'(bus.stall_cnt), 32'd4);
        step(8'h01, 1'b0, 1'b0);
        chk("post_flush", 32'(g_obs), 32'h01);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = NUM_REQ'($urandom());
            if ($urandom_range(0, 2) == 0) r = r & NUM_REQ'($urandom());
            step(r, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end

        // asynchronous reset in the middle of a hold
        step(8'h08, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        bus.req = '1;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        chk("async_rst_grant", 32'(bus.grant), 32'h0);
        @(negedge clk);
        bus.req = '0;
        rst = 1'b1;
        step(8'h24, 1'b0, 1'b1);
        chk("rst_first_grant", 32'(g_obs), 32'h04);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cdb_arbiter.md
# alu_cdb_arbiter

Round-robin scheduler that shares the single common data bus (CDB) among the entries of the ALU reservation station. Each cycle it picks at most one entry whose result is complete. It grants that entry so the station can free the slot, and captures the result and ROB tag into a registered CDB output. The output holds under ROB backpressure. The block sits between the ALU reservation station (requesters) and the ROB / other reservation stations (CDB consumers).

## Interface
Parameters:
- num_req, 8, number of requesters (reservation-station entries)
- req_index_bits, 3, log2(num_req)
- rob_index_bits, 4, width of a ROB tag

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- req  input  num_req  req[i]=1: entry i holds a completed result
- data_req  input  32 x num_req  result of entry i
- tag_req  input  rob_index_bits x num_req  ROB index of entry i
- flush  input  1  pipeline flush; discard held result, no grant this cycle
- cdb_ready  input  1  consumer accepts the CDB word this cycle
- grant  output  num_req  combinational one-hot; grant[i]=1 means entry i is consumed this cycle
- cdb_valid  output  1  registered; CDB word valid
- cdb_data  output  32  registered result
- cdb_tag  output  rob_index_bits  registered ROB tag
- cdb_src  output  req_index_bits  registered index of the granted entry
- stall_cnt  output  16  saturating count of backpressured cycles

## Operation
- Internal state: rr_ptr (req_index_bits), mask (num_req, one-hot or zero), output register, stall_cnt.
- Two-state FSM, encoded by cdb_valid:
  - EMPTY (cdb_valid=0).
  - FULL (cdb_valid=1).
- can_load = !flush && (!cdb_valid || cdb_ready).
- eligible = req & ~mask.
- Selection: the first set bit of eligible scanning rr_ptr, rr_ptr+1, … modulo num_req (wraps from num_req-1 to 0).
- If can_load and eligible≠0, grant is one-hot at the selected index k; otherwise grant=0.
- On an edge with grant[k]=1:
  - cdb_valid←1.
  - cdb_data←data_req[k], cdb_tag←tag_req[k], cdb_src←k.
  - rr_ptr←(k+1) mod num_req.
  - mask←one-hot(k).
- Without a grant:
  - mask←0.
  - rr_ptr unchanged.
  - If cdb_valid && cdb_ready, then cdb_valid←0.
  - Data, tag and src registers hold their last values.
- Transitions:
  - EMPTY→FULL on grant.
  - FULL→FULL on a hold (ready=0), or on drain plus refill (ready=1 and grant).
  - FULL→EMPTY on ready=1 with no grant.
  - Any state→EMPTY on flush.
- The mask blocks re-granting entry k in the cycle right after its grant. This covers the one-cycle lag before the station clears its done bit.
- Flush:
  - grant=0 in the flush cycle.
  - cdb_valid←0 and mask←0.
  - rr_ptr unchanged.
  - stall_cnt not incremented.
  - A flush takes priority over cdb_ready.
- stall_cnt increments when cdb_valid && !cdb_ready && !flush, and saturates at 16'hFFFF.

## Timing
- Reset (rst=0, asynchronous): cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_src=0, rr_ptr=0, mask=0, stall_cnt=0, grant=0. Reset overrides any in-progress hold.
- Latency: req[i] rising in cycle n with the bus free gives grant[i] in cycle n (combinational). cdb_valid=1 with entry i's data appears in cycle n+1.
- Throughput is one CDB word per cycle under a continuously asserted cdb_ready; no bubble on drain plus refill.
- The CDB word is stable from the cycle cdb_valid rises until the cycle after cdb_ready=1 is sampled.
- grant depends combinationally on req, flush, cdb_ready and state. Requesters sample it on the same edge.

## Test plan
- Reset, then req=8'h20 for one cycle with cdb_ready=1:
  - grant=8'h20 in that cycle.
  - Next cycle: cdb_valid=1, cdb_src=5, cdb_data/cdb_tag match entry 5.
  - rr_ptr=6.
  - The cycle after, cdb_valid=0.
- req=8'hFF held 9 cycles, cdb_ready=1, rr_ptr=0:
  - Grants go to entries 0,1,…,7, then 0, one per cycle.
  - cdb_valid stays 1 from cycle 2 onward with no bubble.
- Wrap-around: rr_ptr=6 via a prior grant to entry 5, then req=8'h03:
  - Grant goes to entry 0, then entry 1 on the next cycle.
  - rr_ptr=1, then 2.
- Backpressure: grant entry 2, then cdb_ready=0 for 3 cycles with req=8'h10:
  - grant=0 and the CDB word is held for all 3 cycles; stall_cnt=3.
  - The cycle cdb_ready=1, grant=8'h10; the next cycle cdb_src=4.
- Flush while FULL with req=8'h01 and cdb_ready=0:
  - grant=0 in the flush cycle.
  - Next cycle cdb_valid=0 and stall_cnt unchanged.
  - The following cycle, entry 0 is granted.
- Assert rst=0 asynchronously mid-hold (between edges):
  - cdb_valid, cdb_data, cdb_tag, cdb_src and stall_cnt go to 0 immediately; grant=0.
  - After rst=1, the first grant goes to the lowest requesting index.
